// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, branch type
// codes and the default halting instruction word.
package pc_seq_pkg;

   localparam int unsigned XLEN = 32;

   // Two-bit FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   // Conditional branch type codes
   localparam logic [1:0] BR_BEQ  = 2'b00;
   localparam logic [1:0] BR_BNE  = 2'b01;
   localparam logic [1:0] BR_BGTZ = 2'b10;
   localparam logic [1:0] BR_BLTZ = 2'b11;

   localparam logic [XLEN-1:0] HALT_INST_DEFAULT = 32'h0000_000C;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jump target, taken-branch target or
// pc+4. All address arithmetic is modulo 2^32.
// Ports:
//   pc       in  32  current instruction address
//   inst     in  32  current instruction word (imm16 / target26 fields)
//   branch   in  1   conditional branch
//   br_type  in  2   BEQ/BNE/BGTZ/BLTZ
//   jump     in  1   unconditional jump (wins over branch)
//   zero     in  1   ALU zero flag
//   msb      in  1   ALU result bit 31
//   next_pc  out 32  selected next address
module next_pc_logic
   import pc_seq_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] inst,
   input  logic            branch,
   input  logic [1:0]      br_type,
   input  logic            jump,
   input  logic            zero,
   input  logic            msb,
   output logic [XLEN-1:0] next_pc
);

   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_br_offset;
   logic [XLEN-1:0] w_br_target;
   logic [XLEN-1:0] w_j_target;
   logic            w_taken;
   logic            w_unused;

   // Opcode bits are decoded elsewhere
   assign w_unused = ^inst[31:26];

   assign w_pc_plus4  = pc + 32'd4;
   assign w_br_offset = {{14{inst[15]}}, inst[15:0], 2'b00};
   assign w_br_target = w_pc_plus4 + w_br_offset;
   assign w_j_target  = {w_pc_plus4[31:28], inst[25:0], 2'b00};

   // Branch condition evaluation
   always_comb begin
      w_taken = 1'b0;
      if (branch) begin
         case (br_type)
            BR_BEQ:  w_taken = zero;
            BR_BNE:  w_taken = !zero;
            BR_BGTZ: w_taken = !zero && !msb;
            BR_BLTZ: w_taken = msb;
            default: w_taken = 1'b0;
         endcase
      end
   end

   // Jump has priority over a taken branch
   always_comb begin
      next_pc = w_pc_plus4;
      if (jump)
         next_pc = w_j_target;
      else if (w_taken)
         next_pc = w_br_target;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: IDLE/RUN/HALT control with single-step support,
// commit gating for register file / memory writes and a commit counter.
// Ports:
//   clk, reset (async, active-high)
//   inst, zero, msb, branch, br_type, jump   current instruction context
//   start, stop (levels), step_req (rising edge = one step)
//   pc          current instruction address
//   commit_en   combinational; current instruction may write state
//   step_ack    registered one-cycle pulse after a step commit
//   halted      high while in HALT
//   inst_count  committed instruction count (wraps)
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_INST = HALT_INST_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] inst,
   input  logic            zero,
   input  logic            msb,
   input  logic            branch,
   input  logic [1:0]      br_type,
   input  logic            jump,
   input  logic            start,
   input  logic            stop,
   input  logic            step_req,
   output logic [XLEN-1:0] pc,
   output logic            commit_en,
   output logic            step_ack,
   output logic            halted,
   output logic [XLEN-1:0] inst_count
);

   state_t          r_state;
   state_t          w_next_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_inst_count;
   logic            r_step_req_d;
   logic            r_step_ack;
   logic [XLEN-1:0] w_next_pc;
   logic            w_commit;
   logic            w_halt_hit;
   logic            w_step_edge;
   logic            w_step_commit;

   assign w_halt_hit  = (inst == HALT_INST);
   assign w_step_edge = step_req && !r_step_req_d;

   next_pc_logic u_next_pc (
      .pc      (r_pc),
      .inst    (inst),
      .branch  (branch),
      .br_type (br_type),
      .jump    (jump),
      .zero    (zero),
      .msb     (msb),
      .next_pc (w_next_pc)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   // Next-state and commit decode; stop beats halt, start beats step
   always_comb begin
      w_next_state  = r_state;
      w_commit      = 1'b0;
      w_step_commit = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_commit      = w_step_edge && !start && !w_halt_hit;
            w_step_commit = w_commit;
            if (start)
               w_next_state = ST_RUN;
            else if (w_step_edge && w_halt_hit)
               w_next_state = ST_HALT;
         end
         ST_RUN: begin
            w_commit = !stop && !w_halt_hit;
            if (stop)
               w_next_state = ST_IDLE;
            else if (w_halt_hit)
               w_next_state = ST_HALT;
         end
         ST_HALT: begin
            w_next_state = ST_HALT;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // PC, counter, step edge history and step acknowledge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc         <= RESET_PC;
         r_inst_count <= '0;
         r_step_req_d <= 1'b0;
         r_step_ack   <= 1'b0;
      end else begin
         r_step_req_d <= step_req;
         r_step_ack   <= w_step_commit;
         if (w_commit) begin
            r_pc         <= w_next_pc;
            r_inst_count <= r_inst_count + 32'd1;
         end
      end
   end

   assign pc         = r_pc;
   assign inst_count = r_inst_count;
   assign step_ack   = r_step_ack;
   assign halted     = (r_state == ST_HALT);
   assign commit_en  = w_commit && !reset;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a table of RUN-mode vectors plus
// hand-written sequences for stepping, halting and boundary cases.
module tb_pc_sequencer;
   import pc_seq_pkg::*;

   localparam logic [31:0] NOP     = 32'h0000_0020;
   localparam logic [31:0] HALT    = 32'h0000_000C;
   localparam logic [31:0] BEQ_M2  = 32'h1000_FFFE;
   localparam logic [31:0] BNE_P1  = 32'h1400_0001;
   localparam logic [31:0] BGTZ_M2 = 32'h1C00_FFFE;
   localparam logic [31:0] BLTZ_P2 = 32'h0400_0002;
   localparam logic [31:0] J_40    = 32'h0800_0040;
   localparam logic [31:0] J_MAX   = 32'h0BFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] inst;
   logic        zero, msb, branch, jump, start, stop, step_req;
   logic [1:0]  br_type;
   logic [31:0] pc, inst_count;
   logic        commit_en, step_ack, halted;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .inst       (inst),
      .zero       (zero),
      .msb        (msb),
      .branch     (branch),
      .br_type    (br_type),
      .jump       (jump),
      .start      (start),
      .stop       (stop),
      .step_req   (step_req),
      .pc         (pc),
      .commit_en  (commit_en),
      .step_ack   (step_ack),
      .halted     (halted),
      .inst_count (inst_count)
   );

   typedef struct {
      logic [31:0] inst;
      logic        zero, msb, branch;
      logic [1:0]  br_type;
      logic        jump, start, stop;
      logic        exp_commit;
      logic [31:0] exp_pc;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs[20];

   function automatic vec_t mk(logic [31:0] i, logic z, logic m, logic b, logic [1:0] bt,
                               logic j, logic st, logic sp, logic c, logic [31:0] p, logic [31:0] n);
      vec_t v;
      v.inst = i; v.zero = z; v.msb = m; v.branch = b; v.br_type = bt;
      v.jump = j; v.start = st; v.stop = sp;
      v.exp_commit = c; v.exp_pc = p; v.exp_cnt = n;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      inst = NOP; zero = 0; msb = 0; branch = 0; br_type = BR_BEQ;
      jump = 0; start = 0; stop = 0; step_req = 0;
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      chk({tag, "_rst_pc"}, pc, 32'h0);
      chk({tag, "_rst_commit"}, 32'(commit_en), 32'h0);
      chk({tag, "_rst_cnt"}, inst_count, 32'h0);
      chk({tag, "_rst_halted"}, 32'(halted), 32'h0);
      chk({tag, "_rst_ack"}, 32'(step_ack), 32'h0);
      reset = 1'b0;
   endtask

   initial begin
      // inst, zero, msb, branch, br_type, jump, start, stop, commit, pc_after, cnt_after
      vecs[0]  = mk(NOP,     0, 0, 0, BR_BEQ,  0, 1, 0, 0, 32'h0000_0000, 0);
      vecs[1]  = mk(NOP,     0, 0, 0, BR_BEQ,  0, 1, 0, 1, 32'h0000_0004, 1);
      vecs[2]  = mk(NOP,     0, 0, 0, BR_BEQ,  0, 1, 0, 1, 32'h0000_0008, 2);
      vecs[3]  = mk(NOP,     0, 0, 0, BR_BEQ,  0, 1, 0, 1, 32'h0000_000C, 3);
      vecs[4]  = mk(NOP,     0, 0, 0, BR_BEQ,  0, 1, 0, 1, 32'h0000_0010, 4);
      vecs[5]  = mk(BEQ_M2,  1, 0, 1, BR_BEQ,  0, 1, 0, 1, 32'h0000_000C, 5);
      vecs[6]  = mk(NOP,     0, 0, 0, BR_BEQ,  0, 1, 0, 1, 32'h0000_0010, 6);
      vecs[7]  = mk(BEQ_M2,  0, 0, 1, BR_BEQ,  0, 1, 0, 1, 32'h0000_0014, 7);
      vecs[8]  = mk(BGTZ_M2, 0, 1, 1, BR_BGTZ, 0, 1, 0, 1, 32'h0000_0018, 8);
      vecs[9]  = mk(BGTZ_M2, 0, 0, 1, BR_BGTZ, 0, 1, 0, 1, 32'h0000_0014, 9);
      vecs[10] = mk(BNE_P1,  0, 0, 1, BR_BNE,  0, 1, 0, 1, 32'h0000_001C, 10);
      vecs[11] = mk(BLTZ_P2, 0, 1, 1, BR_BLTZ, 0, 1, 0, 1, 32'h0000_0028, 11);
      vecs[12] = mk(BLTZ_P2, 0, 0, 1, BR_BLTZ, 0, 1, 0, 1, 32'h0000_002C, 12);
      vecs[13] = mk(J_40,    1, 0, 1, BR_BEQ,  1, 1, 0, 1, 32'h0000_0100, 13);
      vecs[14] = mk(BEQ_M2,  1, 0, 0, BR_BEQ,  0, 1, 0, 1, 32'h0000_0104, 14);
      vecs[15] = mk(J_MAX,   0, 0, 0, BR_BEQ,  1, 1, 0, 1, 32'h0FFF_FFFC, 15);
      vecs[16] = mk(NOP,     0, 0, 0, BR_BEQ,  0, 1, 0, 1, 32'h1000_0000, 16);
      vecs[17] = mk(J_40,    0, 0, 0, BR_BEQ,  1, 1, 0, 1, 32'h1000_0100, 17);
      vecs[18] = mk(NOP,     0, 0, 0, BR_BEQ,  0, 0, 1, 0, 32'h1000_0100, 17);
      vecs[19] = mk(NOP,     0, 0, 0, BR_BEQ,  0, 0, 0, 0, 32'h1000_0100, 17);

      // Table: run from reset through branches and jumps
      do_reset("tbl");
      foreach (vecs[i]) begin
         inst = vecs[i].inst; zero = vecs[i].zero; msb = vecs[i].msb;
         branch = vecs[i].branch; br_type = vecs[i].br_type; jump = vecs[i].jump;
         start = vecs[i].start; stop = vecs[i].stop;
         #1;
         chk($sformatf("vec%0d_commit", i), 32'(commit_en), 32'(vecs[i].exp_commit));
         tick();
         chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
         chk($sformatf("vec%0d_cnt", i), inst_count, vecs[i].exp_cnt);
         chk($sformatf("vec%0d_halted", i), 32'(halted), 32'h0);
      end

      // Three single-step pulses
      do_reset("step");
      for (int k = 0; k < 3; k++) begin
         step_req = 1; #1;
         chk($sformatf("step%0d_commit", k), 32'(commit_en), 32'h1);
         tick();
         chk($sformatf("step%0d_pc", k), pc, 32'((k + 1) * 4));
         chk($sformatf("step%0d_ack", k), 32'(step_ack), 32'h1);
         step_req = 0; #1;
         chk($sformatf("step%0d_idle_commit", k), 32'(commit_en), 32'h0);
         tick();
         chk($sformatf("step%0d_ack_low", k), 32'(step_ack), 32'h0);
      end
      chk("step_cnt3", inst_count, 32'd3);

      // Held step request yields exactly one step
      step_req = 1; #1;
      chk("hold_commit", 32'(commit_en), 32'h1);
      tick();
      chk("hold_ack", 32'(step_ack), 32'h1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("hold%0d_commit", k), 32'(commit_en), 32'h0);
         tick();
         chk($sformatf("hold%0d_ack", k), 32'(step_ack), 32'h0);
      end
      step_req = 0;
      tick();
      chk("hold_pc", pc, 32'h10);
      chk("hold_cnt", inst_count, 32'd4);

      // Step onto the halt instruction: no commit, no ack
      inst = HALT; step_req = 1; #1;
      chk("stephalt_commit", 32'(commit_en), 32'h0);
      tick();
      chk("stephalt_halted", 32'(halted), 32'h1);
      chk("stephalt_ack", 32'(step_ack), 32'h0);
      chk("stephalt_pc", pc, 32'h10);

      // HALT ignores start/stop/step
      for (int k = 0; k < 4; k++) begin
         inst = NOP; start = (k == 0 || k == 2); stop = (k == 1);
         step_req = k[0];
         #1;
         chk($sformatf("halt%0d_commit", k), 32'(commit_en), 32'h0);
         tick();
         chk($sformatf("halt%0d_pc", k), pc, 32'h10);
         chk($sformatf("halt%0d_halted", k), 32'(halted), 32'h1);
         chk($sformatf("halt%0d_ack", k), 32'(step_ack), 32'h0);
         chk($sformatf("halt%0d_cnt", k), inst_count, 32'd4);
      end

      // RUN fetches the halt instruction
      do_reset("runhalt");
      start = 1; tick();
      #1; chk("runhalt_c1", 32'(commit_en), 32'h1);
      tick();
      inst = HALT; #1;
      chk("runhalt_commit", 32'(commit_en), 32'h0);
      tick();
      chk("runhalt_halted", 32'(halted), 32'h1);
      chk("runhalt_pc", pc, 32'h4);
      chk("runhalt_cnt", inst_count, 32'd1);
      inst = NOP; start = 0; stop = 1; #1;
      chk("runhalt_stop_commit", 32'(commit_en), 32'h0);
      tick();
      chk("runhalt_stop_halted", 32'(halted), 32'h1);
      chk("runhalt_stop_pc", pc, 32'h4);

      // stop and halt_hit together -> IDLE without commit
      do_reset("stophalt");
      start = 1; tick();
      start = 0; stop = 1; inst = HALT; #1;
      chk("stophalt_commit", 32'(commit_en), 32'h0);
      tick();
      chk("stophalt_halted", 32'(halted), 32'h0);
      chk("stophalt_pc", pc, 32'h0);
      stop = 0; inst = NOP; #1;
      chk("stophalt_idle_commit", 32'(commit_en), 32'h0);
      tick();
      chk("stophalt_idle_pc", pc, 32'h0);

      // start and step edge together -> RUN, no step commit or ack
      start = 1; step_req = 1; #1;
      chk("startstep_commit", 32'(commit_en), 32'h0);
      tick();
      chk("startstep_ack", 32'(step_ack), 32'h0);
      chk("startstep_pc", pc, 32'h0);
      #1; chk("startstep_run_commit", 32'(commit_en), 32'h1);
      tick();
      chk("startstep_run_pc", pc, 32'h4);
      chk("startstep_run_ack", 32'(step_ack), 32'h0);

      // PC wrap at the top of the address space, then reset mid-RUN
      do_reset("wrap");
      start = 1; tick();
      inst = BEQ_M2; branch = 1; zero = 1; br_type = BR_BEQ;
      tick();
      chk("wrap_neg_pc", pc, 32'hFFFF_FFFC);
      inst = NOP; branch = 0; zero = 0;
      tick();
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_cnt", inst_count, 32'd2);
      tick();
      chk("midrun_pc_pre", pc, 32'h4);
      reset = 1; #1;
      chk("midrun_pc", pc, 32'h0);
      chk("midrun_cnt", inst_count, 32'h0);
      chk("midrun_commit", 32'(commit_en), 32'h0);
      tick();
      chk("midrun_hold_pc", pc, 32'h0);
      reset = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
